reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter XLEN, default 32, data width.
REQ-002 Parameter DEPTH, default 8, entry count; power of two, >=2; TAG_W = clog2(DEPTH).
REQ-003 Parameter NUM_CDB, default 6, number of common-data-bus channels.
REQ-004 Parameter REG_AW, default 5, architectural register index width.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port flush  input  1  synchronous clear of all entries.
REQ-008 Port alloc_valid  input  1  issue requests an entry.
REQ-009 Port alloc_rd  input  REG_AW  destination register of issuing instruction.
REQ-010 Port alloc_has_dest  input  1  instruction writes a register (0 for stores).
REQ-011 Port alloc_ready  output  1  entry available.
REQ-012 Port alloc_tag  output  TAG_W  tag given to the allocating instruction (current tail).
REQ-013 Port cdb_valid  input  NUM_CDB  per-channel result valid.
REQ-014 Port cdb_tag  input  NUM_CDB*TAG_W  packed per-channel tags, channel i at bits [i*TAG_W +: TAG_W].
REQ-015 Port cdb_data  input  NUM_CDB*XLEN  packed per-channel results, same packing.
REQ-016 Port src_tag0, src_tag1  input  TAG_W each  operand lookup tags.
REQ-017 Port src_ready0, src_ready1  output  1 each  looked-up value available.
REQ-018 Port src_data0, src_data1  output  XLEN each  looked-up value.
REQ-019 Port commit_wen  output  1  register-file write enable, registered.
REQ-020 Port commit_idx  output  REG_AW  register-file write index, registered.
REQ-021 Port commit_data  output  XLEN  register-file write data, registered.
REQ-022 Port commit_tag  output  TAG_W  tag of retired entry, registered.
REQ-023 Port commit_valid  output  1  one-cycle pulse per retired entry, registered.
REQ-024 Port count  output  TAG_W+1  occupied entries; empty, full outputs 1 each, derived from count.

Function
REQ-025 Entry state: busy, done, rd, has_dest, value; circular buffer with head, tail pointers wrapping modulo DEPTH.
REQ-026 alloc_ready = (count < DEPTH), from registered state only; a same-cycle commit does not raise alloc_ready.
REQ-027 alloc_tag = tail combinationally; on alloc_valid && alloc_ready: entry[tail] busy=1, done=0, rd/has_dest latched, tail+1.
REQ-028 CDB: on edge, for each busy, not-done entry e, if any channel i has cdb_valid[i] and tag==e, set done=1 and latch value; lowest matching i wins.
REQ-029 CDB tag naming a non-busy entry, or the entry allocated in the same cycle, is ignored.
REQ-030 Retire: on edge, if entry[head] busy && done: clear busy, head+1, commit_valid<=1, commit_wen<=has_dest, commit_idx<=rd, commit_data<=value, commit_tag<=head; else commit_valid<=0, commit_wen<=0.
REQ-031 At most one retire per cycle; an entry marked done at edge N retires no earlier than edge N+1, commit outputs visible after that edge.
REQ-032 count next = count + alloc - retire; simultaneous alloc and retire leave count unchanged.
REQ-033 Lookup (each port independently): entry done -> ready=1, data=value; else CDB channel matching with valid this cycle -> ready=1, data=that channel (lowest index); else ready=0, data=0.
REQ-034 Lookup of non-busy entry returns ready=0, data=0.
REQ-035 flush has priority over alloc, CDB and retire in the same cycle: all busy/done cleared, head=tail=count=0, commit_valid/commit_wen<=0.

Reset
REQ-036 rst_n low asynchronously clears all entry busy/done, head, tail, count, and all commit outputs to 0; alloc_ready=1, empty=1, full=0 while in reset.
REQ-037 Reset asserted mid-operation discards all in-flight entries; first allocation after release receives tag 0.

Verification
REQ-038 Reset, alloc rd=3 has_dest=1 (tag 0), CDB ch2 tag0 data 0x55 -> next cycle no commit, following edge commit_wen=1, commit_idx=3, commit_data=0x55, commit_tag=0.
REQ-039 Allocate tags 0,1,2; complete 2 then 1 then 0 on CDB -> commits strictly in order 0,1,2 on consecutive cycles after tag 0 completes.
REQ-040 Fill DEPTH=8 entries -> full=1, alloc_ready=0, count=8; complete head and hold alloc_valid -> allocation accepted only the cycle after retire, tag 0 reused (wrap).
REQ-041 Same cycle ch0 and ch4 both tag 1, data 0xA and 0xB -> entry 1 value 0xA; lookup src_tag0=1 that cycle returns ready=1, data 0xA.
REQ-042 Alloc store (has_dest=0) and complete -> commit_valid=1, commit_wen=0.
REQ-043 5 entries busy, flush together with alloc_valid and CDB valid -> count=0, empty=1, no commit pulse, next alloc_tag=0.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: results arrive out of order on several common data buses
// and retire one per cycle in allocation order; issue can look up operands by tag.
module reorder_buffer #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 6,
  parameter int REG_AW  = 5,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [REG_AW-1:0]        alloc_rd,
  input  logic                     alloc_has_dest,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  input  logic [TAG_W-1:0]         src_tag0,
  input  logic [TAG_W-1:0]         src_tag1,
  output logic                     src_ready0,
  output logic                     src_ready1,
  output logic [XLEN-1:0]          src_data0,
  output logic [XLEN-1:0]          src_data1,
  output logic                     commit_wen,
  output logic [REG_AW-1:0]        commit_idx,
  output logic [XLEN-1:0]          commit_data,
  output logic [TAG_W-1:0]         commit_tag,
  output logic                     commit_valid,
  output logic [TAG_W:0]           count,
  output logic                     empty,
  output logic                     full
);

  logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
  logic [DEPTH-1:0]  has_dest_q, has_dest_d;
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [REG_AW-1:0] rd_d [DEPTH];
  logic [XLEN-1:0]   value_q [DEPTH];
  logic [XLEN-1:0]   value_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              commit_valid_q, commit_valid_d, commit_wen_q, commit_wen_d;
  logic [REG_AW-1:0] commit_idx_q, commit_idx_d;
  logic [XLEN-1:0]   commit_data_q, commit_data_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;

  logic [DEPTH-1:0]  cdb_hit;
  logic [XLEN-1:0]   cdb_val [DEPTH];
  logic              alloc_fire, retire;

  // Per-entry CDB match; scanning downward leaves the lowest channel in place.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      cdb_hit[e] = 1'b0;
      cdb_val[e] = '0;
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
        if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == TAG_W'(e))) begin
          cdb_hit[e] = 1'b1;
          cdb_val[e] = cdb_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign alloc_ready = (count_q < (TAG_W+1)'(DEPTH));
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign retire      = busy_q[head_q] && done_q[head_q];
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == (TAG_W+1)'(DEPTH));

  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    has_dest_d     = has_dest_q;
    rd_d           = rd_q;
    value_d        = value_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_wen_d   = 1'b0;
    commit_idx_d   = commit_idx_q;
    commit_data_d  = commit_data_q;
    commit_tag_d   = commit_tag_q;
    if (flush) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // The tail entry is never busy when allocation fires, so CDB hits on it drop out here.
      for (int e = 0; e < DEPTH; e++) begin
        if (busy_q[e] && !done_q[e] && cdb_hit[e]) begin
          done_d[e]  = 1'b1;
          value_d[e] = cdb_val[e];
        end
      end
      if (retire) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + TAG_W'(1);
        commit_valid_d = 1'b1;
        commit_wen_d   = has_dest_q[head_q];
        commit_idx_d   = rd_q[head_q];
        commit_data_d  = value_q[head_q];
        commit_tag_d   = head_q;
      end
      if (alloc_fire) begin
        busy_d[tail_q]     = 1'b1;
        done_d[tail_q]     = 1'b0;
        rd_d[tail_q]       = alloc_rd;
        has_dest_d[tail_q] = alloc_has_dest;
        tail_d             = tail_q + TAG_W'(1);
      end
      count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_wen_q   <= 1'b0;
      commit_idx_q   <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_wen_q   <= commit_wen_d;
      commit_idx_q   <= commit_idx_d;
      commit_data_q  <= commit_data_d;
      commit_tag_q   <= commit_tag_d;
    end
  end

  // Entry payload is qualified by busy/done, so it needs no reset.
  always_ff @(posedge clk) begin
    has_dest_q <= has_dest_d;
    rd_q       <= rd_d;
    value_q    <= value_d;
  end

  assign commit_valid = commit_valid_q;
  assign commit_wen   = commit_wen_q;
  assign commit_idx   = commit_idx_q;
  assign commit_data  = commit_data_q;
  assign commit_tag   = commit_tag_q;

  always_comb begin
    src_ready0 = 1'b0;
    src_data0  = '0;
    src_ready1 = 1'b0;
    src_data1  = '0;
    if (busy_q[src_tag0]) begin
      if (done_q[src_tag0]) begin
        src_ready0 = 1'b1;
        src_data0  = value_q[src_tag0];
      end else if (cdb_hit[src_tag0]) begin
        src_ready0 = 1'b1;
        src_data0  = cdb_val[src_tag0];
      end
    end
    if (busy_q[src_tag1]) begin
      if (done_q[src_tag1]) begin
        src_ready1 = 1'b1;
        src_data1  = value_q[src_tag1];
      end else if (cdb_hit[src_tag1]) begin
        src_ready1 = 1'b1;
        src_data1  = cdb_val[src_tag1];
      end
    end
  end

endmodule
